vector_forward_buffer: RTL
==========================

Name: vector_forward_buffer

Overview:
- Parametrised vector operand bypass for the vector pipeline, sitting between vector register read (VRR) and vector execute (VEXE).
- Keeps the last DEPTH writebacks in a small age-ordered buffer, so consumers that issue several cycles after a producer still see fresh data before the register file write lands.
- Adds a busy-register scoreboard for multi-cycle producers. It raises a stall when a source operand is still in flight and cannot be forwarded.

Parameters:
- DATA_W, 128, vector register data width in bits
- VREG_AW, 5, vector register index width
- DEPTH, 2, retained writeback entries (legal range 1..4)
- NUM_SRC, 3, source operand channels (vs1, vs2, vs3/old-vd)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; invalidates buffer and scoreboard
- issue_valid_i  in  1  an instruction with a vector destination enters VEXE this cycle
- issue_vd_i  in  VREG_AW  destination of the issuing instruction
- src_idx_i  in  NUM_SRC*VREG_AW  source register indices from VRR, channel k at bits [k*VREG_AW +: VREG_AW]
- src_rf_data_i  in  NUM_SRC*DATA_W  register-file read data per channel
- wb_valid_i  in  1  writeback valid
- wb_vd_i  in  VREG_AW  writeback destination
- wb_data_i  in  DATA_W  writeback data
- src_data_o  out  NUM_SRC*DATA_W  forwarded operand per channel
- src_fwd_o  out  NUM_SRC  per-channel flag: operand came from bypass
- stall_o  out  1  a source is busy and not forwardable

Behaviour:
- Reset: all buffer valid bits 0, scoreboard all 0. stall_o=0, src_fwd_o=0, src_data_o=src_rf_data_i.
- Buffer: shift register of DEPTH entries {valid, vd, data}; entry 0 is the youngest.
- Buffer update: on wb_valid_i, the writeback shifts into entry 0 and the oldest entry drops out. With no writeback, entry contents hold.
- Lookup is combinational, zero latency. Per channel, priority order: live writeback port (wb_valid_i && wb_vd_i==idx), then entry 0, then up to entry DEPTH-1, then register file. The first match wins.
- Duplicate vd in the buffer is legal; the youngest matching entry wins.
- Scoreboard: busy[VREG] bit array, 2**VREG_AW bits.
  - issue_valid_i sets busy[issue_vd_i].
  - wb_valid_i clears busy[wb_vd_i].
  - Set and clear on the same index in the same cycle: set wins (a new producer supersedes).
- stall_o = OR over channels of (busy[idx] && !(wb_valid_i && wb_vd_i==idx)). It is combinational; VRR holds its inputs while stall_o=1.
- A buffer hit on a busy register does not cancel the stall. Busy means a newer producer is pending, so the stall stands.
- flush_i is synchronous. Next cycle, all valids and all busy bits are 0. A writeback in the same cycle as a flush is discarded.
- rstn_i asserted mid-operation: asynchronous clear, same state as reset.
- Widths: no arithmetic. Register index compare is on the full VREG_AW bits.

Optional Feature:
- Macro: VFWD_PERF_CNT_EN.
- With the macro defined:
  - Extra outputs fwd_hit_cnt_o[31:0] and stall_cnt_o[31:0].
  - fwd_hit_cnt_o increments by popcount(src_fwd_o) each cycle.
  - stall_cnt_o increments each cycle stall_o=1.
  - Both counters wrap at 2^32, reset to 0 on rstn_i, and are not cleared by flush_i.
- Without the macro: no counter ports or logic; the rest of the behaviour is identical.

Decomposition:
- Package vector_fwd_pkg holds:
  - typedef vfwd_entry_t {valid, vd, data}
  - constants VFWD_DEPTH_MAX=4 and VREG_NUM=2**VREG_AW
- Sub-module vector_fwd_lookup, one per source channel: combinational priority select over the wb port, buffer entries and the RF.
- The top level owns the shift buffer, the scoreboard, stall generation and the optional counters.

Test Plan:
- Reset then idle: src_idx=v3, rf data 0xA..A. Required: src_data=0xA..A, src_fwd=0, stall=0.
- wb v5=0x11 at cycle 0, then vs1=v5 at cycle 1. Required: src_data[0]=0x11, src_fwd[0]=1. Same read at cycle DEPTH+1 with no further writebacks: still 0x11. After DEPTH further writebacks to other registers: RF data returned.
- Writebacks v7=0x1 then v7=0x2, read v7. Required: 0x2 (youngest wins). Also a live wb v7=0x3 in the same cycle as the read: 0x3.
- Issue vd=v9, then read vs2=v9 with no writeback. Required: stall=1. wb v9 arrives: stall=0 and data is forwarded that cycle. Next cycle: busy[v9]=0.
- Same-cycle issue vd=v4 and wb v4. Required: busy[v4]=1 afterwards, and a read of v4 on the next cycle stalls.
- flush_i with two valid entries and v2 busy. Required: next cycle, reads of those registers return RF data with stall=0. With VFWD_PERF_CNT_EN, counters match the expected hit and stall totals across the sequence.

Source files
------------

// File: rtl/vector_fwd_pkg.sv
// Shared types and constants for the vector operand bypass.
// Buffer entries are stored at the package widths; narrower parameterisations zero-extend.
package vector_fwd_pkg;

  localparam int unsigned VFWD_DEPTH_MAX = 4;
  localparam int unsigned VFWD_DATA_W    = 128;
  localparam int unsigned VFWD_VREG_AW   = 5;
  localparam int unsigned VREG_NUM       = 2 ** VFWD_VREG_AW;

  typedef struct packed {
    logic                    valid;
    logic [VFWD_VREG_AW-1:0] vd;
    logic [VFWD_DATA_W-1:0]  data;
  } vfwd_entry_t;

endpackage

// File: rtl/vector_fwd_lookup.sv
// One source channel of the bypass: priority select over the live writeback,
// the retained writebacks (entry 0 youngest) and the register file.
module vector_fwd_lookup
  import vector_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = VFWD_DATA_W,
  parameter int unsigned VREG_AW = VFWD_VREG_AW,
  parameter int unsigned DEPTH   = 2
) (
  input  logic [VREG_AW-1:0]      i_idx,
  input  logic [DATA_W-1:0]       i_rf_data,
  input  logic                    i_wb_valid,
  input  logic [VREG_AW-1:0]      i_wb_vd,
  input  logic [DATA_W-1:0]       i_wb_data,
  input  vfwd_entry_t [DEPTH-1:0] i_entries,
  output logic [DATA_W-1:0]       o_data_c,
  output logic                    o_fwd_c
);

  // Walk oldest to youngest so the youngest match overrides; the live port overrides all.
  always_comb begin
    o_data_c = i_rf_data;
    o_fwd_c  = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (i_entries[i].valid && (i_entries[i].vd == VFWD_VREG_AW'(i_idx))) begin
        o_data_c = DATA_W'(i_entries[i].data);
        o_fwd_c  = 1'b1;
      end
    end
    if (i_wb_valid && (i_wb_vd == i_idx)) begin
      o_data_c = i_wb_data;
      o_fwd_c  = 1'b1;
    end
  end

endmodule

// File: rtl/vector_forward_buffer.sv
// Vector operand bypass between VRR and VEXE: retained-writeback buffer, busy scoreboard, stall.
// Define VFWD_PERF_CNT_EN to add forward-hit and stall cycle counters.
module vector_forward_buffer
  import vector_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = VFWD_DATA_W,
  parameter int unsigned VREG_AW = VFWD_VREG_AW,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NUM_SRC = 3
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  input  logic [VREG_AW-1:0]          issue_vd_i,
  input  logic [NUM_SRC*VREG_AW-1:0]  src_idx_i,
  input  logic [NUM_SRC*DATA_W-1:0]   src_rf_data_i,
  input  logic                        wb_valid_i,
  input  logic [VREG_AW-1:0]          wb_vd_i,
  input  logic [DATA_W-1:0]           wb_data_i,
  output logic [NUM_SRC*DATA_W-1:0]   src_data_o,
  output logic [NUM_SRC-1:0]          src_fwd_o,
  output logic                        stall_o
`ifdef VFWD_PERF_CNT_EN
  ,
  output logic [31:0]                 fwd_hit_cnt_o,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned NREG = 1 << VREG_AW;

  vfwd_entry_t [DEPTH-1:0] r_buf;
  logic [NREG-1:0]         r_busy;
  logic [NREG-1:0]         w_busy_nxt;
  logic [NUM_SRC-1:0]      w_src_busy;

  // Age-ordered shift buffer; entry 0 receives each writeback.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_buf <= '0;
    end else if (flush_i) begin
      r_buf <= '0;
    end else if (wb_valid_i) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        r_buf[i] <= r_buf[i-1];
      end
      r_buf[0] <= '{valid: 1'b1,
                    vd:    VFWD_VREG_AW'(wb_vd_i),
                    data:  VFWD_DATA_W'(wb_data_i)};
    end
  end

  // Clear first, then set, so a same-cycle new producer keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid_i) begin
      w_busy_nxt[wb_vd_i] = 1'b0;
    end
    if (issue_valid_i) begin
      w_busy_nxt[issue_vd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_busy <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar k = 0; k < int'(NUM_SRC); k++) begin : g_src
    vector_fwd_lookup #(
      .DATA_W  (DATA_W),
      .VREG_AW (VREG_AW),
      .DEPTH   (DEPTH)
    ) u_lookup (
      .i_idx      (src_idx_i[k*VREG_AW +: VREG_AW]),
      .i_rf_data  (src_rf_data_i[k*DATA_W +: DATA_W]),
      .i_wb_valid (wb_valid_i),
      .i_wb_vd    (wb_vd_i),
      .i_wb_data  (wb_data_i),
      .i_entries  (r_buf),
      .o_data_c   (src_data_o[k*DATA_W +: DATA_W]),
      .o_fwd_c    (src_fwd_o[k])
    );
  end

  // A buffer hit does not clear a stall: busy means a newer producer is still pending.
  always_comb begin
    w_src_busy = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      w_src_busy[k] = r_busy[src_idx_i[k*VREG_AW +: VREG_AW]] &&
                      !(wb_valid_i && (wb_vd_i == src_idx_i[k*VREG_AW +: VREG_AW]));
    end
  end

  assign stall_o = |w_src_busy;

`ifdef VFWD_PERF_CNT_EN
  logic [31:0] r_fwd_hit_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] w_hit_pop;

  always_comb begin
    w_hit_pop = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      w_hit_pop = w_hit_pop + 32'(src_fwd_o[k]);
    end
  end

  // Free-running wrap-around counters; only reset clears them.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fwd_hit_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_fwd_hit_cnt <= r_fwd_hit_cnt + w_hit_pop;
      r_stall_cnt   <= r_stall_cnt + 32'(stall_o);
    end
  end

  assign fwd_hit_cnt_o = r_fwd_hit_cnt;
  assign stall_cnt_o   = r_stall_cnt;
`endif

endmodule
